// File: rtl/ula_param_if.sv
// Operation request / result handshake bundle for ula_param.
// The master drives operands and consumes results; the slave is the ALU.
interface ula_param_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag_zero;
    logic             flag_neg;
    logic             flag_carry;
    logic             flag_ovf;
    logic             flag_err;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, flag_zero, flag_neg, flag_carry, flag_ovf, flag_err
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, flag_zero, flag_neg, flag_carry, flag_ovf, flag_err
    );
endinterface

// File: rtl/ula_param.sv
// Parameterised ALU with valid/ready handshake: single-cycle logic/arith ops
// and a WIDTH-cycle shift-add multiplier; results held until consumed.
module ula_param #(
    parameter int unsigned WIDTH = 32
) (
    input logic        clk,
    input logic        rst,
    ula_param_if.slave bus
);
    localparam int unsigned SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StCalc, StHold} state_t;

    state_t             state_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [WIDTH-1:0]   result_q;
    logic               zero_q;
    logic               neg_q;
    logic               carry_q;
    logic               ovf_q;
    logic               err_q;

    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [SHW-1:0]     count_q;

    logic [WIDTH-1:0]   alu_res;
    logic               alu_carry;
    logic               alu_ovf;
    logic               alu_err;
    logic [WIDTH:0]     add_full;
    logic [WIDTH-1:0]   sub_res;
    logic [SHW-1:0]     shamt;
    logic [2*WIDTH-1:0] acc_next;

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        alu_err   = 1'b0;
        add_full  = {1'b0, bus.a} + {1'b0, bus.b};
        sub_res   = bus.a - bus.b;
        shamt     = bus.b[SHW-1:0];
        case (bus.op)
            4'd0: begin
                alu_res   = add_full[WIDTH-1:0];
                alu_carry = add_full[WIDTH];
                alu_ovf   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                            (add_full[WIDTH-1] != bus.a[WIDTH-1]);
            end
            4'd1: begin
                alu_res   = sub_res;
                alu_carry = bus.a < bus.b;
                alu_ovf   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                            (sub_res[WIDTH-1] != bus.a[WIDTH-1]);
            end
            4'd2: alu_res = bus.a & bus.b;
            4'd3: alu_res = bus.a | bus.b;
            4'd4: alu_res = bus.a ^ bus.b;
            4'd5: alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            4'd6: alu_res = bus.a << shamt;
            4'd7: alu_res = $signed(bus.a) >>> shamt;
            4'd8: alu_res = '0;
            default: alu_err = 1'b1;
        endcase
    end

    // Accumulator value including the current iteration's partial product.
    always_comb begin
        acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            count_q     <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        in_ready_q <= 1'b0;
                        if (bus.op == 4'd8) begin
                            acc_q    <= '0;
                            mcand_q  <= {{WIDTH{1'b0}}, bus.a};
                            mplier_q <= bus.b;
                            count_q  <= '0;
                            state_q  <= StCalc;
                        end else begin
                            result_q    <= alu_res;
                            zero_q      <= (alu_res == '0);
                            neg_q       <= alu_res[WIDTH-1];
                            carry_q     <= alu_carry;
                            ovf_q       <= alu_ovf;
                            err_q       <= alu_err;
                            out_valid_q <= 1'b1;
                            state_q     <= StHold;
                        end
                    end
                end
                StCalc: begin
                    acc_q    <= acc_next;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    count_q  <= count_q + SHW'(1);
                    if (count_q == SHW'(WIDTH - 1)) begin
                        result_q    <= acc_next[WIDTH-1:0];
                        zero_q      <= (acc_next[WIDTH-1:0] == '0);
                        neg_q       <= acc_next[WIDTH-1];
                        carry_q     <= 1'b0;
                        ovf_q       <= |acc_next[2*WIDTH-1:WIDTH];
                        err_q       <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= StHold;
                    end
                end
                StHold: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= StIdle;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.result     = result_q;
    assign bus.flag_zero  = zero_q;
    assign bus.flag_neg   = neg_q;
    assign bus.flag_carry = carry_q;
    assign bus.flag_ovf   = ovf_q;
    assign bus.flag_err   = err_q;
endmodule

// File: tb/tb_ula_param.sv
// Self-checking bench for ula_param (WIDTH=32): directed cases plus random
// operations compared against an arithmetic reference model.
module tb_ula_param;
    localparam int unsigned W = 32;

    logic        clk = 1'b0;
    logic        rst;
    int unsigned total = 0;
    int unsigned passed = 0;

    ula_param_if #(.WIDTH(W)) bus ();

    ula_param #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] res;
        logic        z;
        logic        n;
        logic        c;
        logic        v;
        logic        e;
    } exp_t;

    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t            r;
        longint          sa;
        longint          sb;
        longint          s;
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned p;
        r  = '0;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        case (op)
            4'd0: begin
                p = ua + ub;
                r.res = p[31:0];
                r.c = p[32];
                s = sa + sb;
                r.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd1: begin
                r.res = a - b;
                r.c = (ua < ub);
                s = sa - sb;
                r.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd2: r.res = a & b;
            4'd3: r.res = a | b;
            4'd4: r.res = a ^ b;
            4'd5: r.res = (sa < sb) ? 32'd1 : 32'd0;
            4'd6: r.res = a << (b % 32);
            4'd7: begin
                s = sa >>> (b % 32);
                r.res = s[31:0];
            end
            4'd8: begin
                p = ua * ub;
                r.res = p[31:0];
                r.v = (p[63:32] != 0);
            end
            default: r.e = 1'b1;
        endcase
        r.z = (r.res == 0);
        r.n = r.res[31];
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [4:0] flags();
        return {bus.flag_zero, bus.flag_neg, bus.flag_carry, bus.flag_ovf, bus.flag_err};
    endfunction

    // Issue one op, scramble inputs after accept, check latency/result, hold, release.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int hold);
        exp_t e;
        int   n;
        e = model(op, a, b);
        @(negedge clk);
        check("ready_before", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.op = op;
        bus.a = a;
        bus.b = b;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.op = 4'($urandom);
        bus.a = $urandom;
        bus.b = $urandom;
        n = 1;
        while (!bus.out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check($sformatf("latency op%0d", op), n, (op == 4'd8) ? W + 1 : 1);
        check($sformatf("result op%0d a=%h b=%h", op, a, b), bus.result, e.res);
        check($sformatf("flags op%0d a=%h b=%h", op, a, b), flags(), {e.z, e.n, e.c, e.v, e.e});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.op = 4'd0;
            bus.a = $urandom;
            bus.b = $urandom;
            @(posedge clk);
            #1;
            check("hold_ctrl", {bus.out_valid, bus.in_ready}, 2'b10);
            check("hold_result", bus.result, e.res);
            check("hold_flags", flags(), {e.z, e.n, e.c, e.v, e.e});
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release", {bus.in_ready, bus.out_valid}, 2'b10);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int seen;
        logic [31:0] ra;
        logic [31:0] rb;

        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.op = '0;
        bus.a = '0;
        bus.b = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ctrl", {bus.in_ready, bus.out_valid}, 2'b10);
        check("reset_result", bus.result, 0);
        check("reset_flags", flags(), 5'b0);
        @(negedge clk);
        rst = 1'b0;

        run_op(4'd0, 32'hFFFF_FFFF, 32'h1, 0);
        run_op(4'd1, 32'h8000_0000, 32'h1, 0);
        run_op(4'd5, 32'hFFFF_FFFF, 32'h1, 0);
        run_op(4'd8, 32'h0001_0000, 32'h0001_0000, 0);
        run_op(4'd8, 32'd7, 32'd6, 0);
        run_op(4'd0, 32'h1234_5678, 32'h1111_1111, 5);
        run_op(4'd7, 32'h8000_0000, 32'h24, 0);
        run_op(4'd6, 32'h1, 32'h1F, 0);
        run_op(4'd1, 32'h5, 32'h7, 0);

        // Reset ten cycles into a multiply abandons it.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op = 4'd8;
        bus.a = 32'd5;
        bus.b = 32'd7;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("midmul_rst_ctrl", {bus.in_ready, bus.out_valid}, 2'b10);
        check("midmul_rst_result", bus.result, 0);
        check("midmul_rst_flags", flags(), 5'b0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen++;
        end
        check("abandoned_no_valid", seen, 0);
        bus.out_ready = 1'b0;
        run_op(4'd12, 32'hDEAD_BEEF, 32'h1, 0);

        // Reset wins over a same-edge request.
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.op = 4'd3;
        bus.a = 32'hF0F0_F0F0;
        @(posedge clk);
        #1;
        check("rst_priority", {bus.in_ready, bus.out_valid}, 2'b10);
        @(negedge clk);
        rst = 1'b0;
        bus.in_valid = 1'b0;

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 5 == 0) ra = 32'h8000_0000;
            if (i % 7 == 0) rb = 32'hFFFF_FFFF;
            if (i % 3 == 0) rb = rb & 32'hFFFF;
            run_op(4'($urandom_range(0, 15)), ra, rb, $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
